bp_pht_ctrl: RTL

BP_PHT_CTRL -- requirements
Module: bp_pht_ctrl

---
 rtl/bp_pkg.sv | 21 ++
 rtl/bp_upd_fifo.sv | 53 +++++
 rtl/bp_pht_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the pattern-history-table update controller.
package bp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam logic [1:0] INIT_VAL_DEF = WNT;

  function automatic logic [1:0] sat2_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST) ? ST : cnt + 2'd1;
    else       return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Circular update queue; flush empties it at the next edge, overriding any push.
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_pht_ctrl.sv
// PHT maintenance: sweeps the table to INIT_VAL, then drains queued branch
// outcomes through a single read-modify-write port.
module bp_pht_ctrl
  import bp_pkg::*;
#(
  parameter int         PHT_DEPTH = 7,
  parameter logic [1:0] INIT_VAL  = INIT_VAL_DEF,
  parameter int         QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reinit,
  input  logic                 upd_valid,
  input  logic [PHT_DEPTH-1:0] upd_index,
  input  logic                 upd_taken,
  output logic                 upd_ready,
  output logic [PHT_DEPTH-1:0] pht_raddr,
  input  logic [1:0]           pht_rdata,
  output logic                 pht_we,
  output logic [PHT_DEPTH-1:0] pht_waddr,
  output logic [1:0]           pht_wdata,
  output logic                 init_done,
  output logic [7:0]           drop_cnt
);
  localparam int QW = PHT_DEPTH + 1;
  localparam logic [PHT_DEPTH-1:0] SWEEP_LAST = '1;

  state_t               state;
  logic [PHT_DEPTH-1:0] sweep_idx;
  logic [PHT_DEPTH-1:0] hold_idx;
  logic                 q_full;
  logic                 q_empty;
  logic [QW-1:0]        q_head;
  logic [PHT_DEPTH-1:0] head_idx;
  logic                 head_taken;
  logic                 push;
  logic                 pop;

  assign {head_idx, head_taken} = q_head;
  assign upd_ready = (state == ST_RUN) && !q_full;
  assign push      = upd_valid && upd_ready;
  assign pop       = (state == ST_RUN) && !q_empty;

  bp_upd_fifo #(
    .DEPTH(QDEPTH),
    .WIDTH(QW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (reinit),
    .push  (push),
    .din   ({upd_index, upd_taken}),
    .pop   (pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Port drive: the RMW result depends on same-cycle combinational read data
  always_comb begin
    pht_we    = 1'b0;
    pht_raddr = hold_idx;
    pht_waddr = hold_idx;
    pht_wdata = INIT_VAL;
    if (state == ST_INIT) begin
      pht_we    = 1'b1;
      pht_waddr = sweep_idx;
    end else if (pop) begin
      pht_we    = 1'b1;
      pht_raddr = head_idx;
      pht_waddr = head_idx;
      pht_wdata = sat2_update(pht_rdata, head_taken);
    end
  end

  // Keeps idle addresses stable at the last drained index
  always_ff @(posedge clk) begin
    if (pop) hold_idx <= head_idx;
  end

  always_ff @(posedge clk) begin
    if (rst || reinit) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      sweep_idx <= sweep_idx + 1'b1;
      if (sweep_idx == SWEEP_LAST) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                           drop_cnt <= '0;
    else if (upd_valid && !upd_ready && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule
